// File: rtl/hdmi_cfg_pkg.sv
// Shared types and the register table for the HDMI transmitter configuration sequencer.
package hdmi_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SEND_DEV,
    SEND_REG,
    SEND_DATA,
    WAIT_RSP,
    NEXT,
    BACKOFF,
    DONE,
    FAIL
  } state_t;

  // Which byte of the 3-byte write is currently outstanding at the master.
  typedef enum logic [1:0] {
    BYTE_DEV,
    BYTE_REG,
    BYTE_DATA
  } byte_sel_t;

  localparam int NUM_ENTRIES = 10;

  // {register, data} pairs written in order on every pass.
  localparam logic [15:0] CFG_TABLE [NUM_ENTRIES] = '{
    16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61,
    16'hA2A4, 16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500
  };

endpackage

// File: rtl/hdmi_cfg_rom.sv
// Combinational lookup of one {register, data} table entry; out-of-range indices read as zero.
module hdmi_cfg_rom
  import hdmi_cfg_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data
);

  always_comb begin
    reg_addr = '0;
    reg_data = '0;
    if (int'(idx) < NUM_ENTRIES) begin
      {reg_addr, reg_data} = CFG_TABLE[idx];
    end
  end

endmodule

// File: rtl/hdmi_cfg_sequencer.sv
// Walks the configuration table and writes each entry to the HDMI transmitter through an
// external I2C byte master, with per-entry NACK retry/backoff and hot-plug restart.
module hdmi_cfg_sequencer
  import hdmi_cfg_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR    = 8'h72,
  parameter int          RETRY_MAX   = 3,
  parameter logic [15:0] BACKOFF_CYC = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hpd,
  output logic       req_valid,
  input  logic       req_ready,
  output logic [7:0] req_byte,
  output logic       req_start,
  output logic       req_stop,
  input  logic       rsp_valid,
  input  logic       rsp_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] entry_idx
);

  localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);
  localparam logic [3:0] LAST_IDX = 4'(NUM_ENTRIES - 1);

  state_t             state, state_nxt;
  byte_sel_t          sel, sel_nxt;
  logic [3:0]         idx, idx_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic [15:0]        bo_cnt, bo_cnt_nxt;
  logic               done_q, done_nxt;
  logic               err_q, err_nxt;
  logic               pend, pend_nxt;
  logic               hpd_q;
  logic               hpd_rise;
  logic               hs;
  logic               restart;
  logic               take;
  logic               bo_last;
  logic [7:0]         rom_reg, rom_data;

  hdmi_cfg_rom u_rom (
    .idx      (idx),
    .reg_addr (rom_reg),
    .reg_data (rom_data)
  );

  assign hpd_rise = hpd & ~hpd_q;
  assign hs       = req_valid & req_ready;
  // A rise arriving on the very cycle a restart point is reached counts as pending.
  assign restart  = pend | hpd_rise;
  // Zero-extended so that BACKOFF_CYC of 0 still leaves after one cycle instead of wrapping.
  assign bo_last  = ({1'b0, bo_cnt} + 17'd1) >= {1'b0, BACKOFF_CYC};

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign error     = err_q;
  assign entry_idx = idx;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= BYTE_DEV;
      idx    <= '0;
      retry  <= '0;
      bo_cnt <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      pend   <= 1'b0;
      hpd_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      idx    <= idx_nxt;
      retry  <= retry_nxt;
      bo_cnt <= bo_cnt_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
      pend   <= pend_nxt;
      hpd_q  <= hpd;
    end
  end

  // ---- next state and request outputs ----
  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    idx_nxt    = idx;
    retry_nxt  = retry;
    bo_cnt_nxt = bo_cnt;
    done_nxt   = done_q;
    err_nxt    = err_q;
    pend_nxt   = pend | (hpd_rise && (state != IDLE));
    take       = 1'b0;
    req_valid  = 1'b0;
    req_byte   = '0;
    req_start  = 1'b0;
    req_stop   = 1'b0;

    case (state)
      IDLE: begin
        if (start || hpd_rise) begin
          take = 1'b1;
        end
      end

      SEND_DEV: begin
        req_valid = 1'b1;
        req_byte  = DEV_ADDR;
        req_start = 1'b1;
        if (hs) begin
          sel_nxt   = BYTE_DEV;
          state_nxt = WAIT_RSP;
        end
      end

      SEND_REG: begin
        req_valid = 1'b1;
        req_byte  = rom_reg;
        if (hs) begin
          sel_nxt   = BYTE_REG;
          state_nxt = WAIT_RSP;
        end
      end

      SEND_DATA: begin
        req_valid = 1'b1;
        req_byte  = rom_data;
        req_stop  = 1'b1;
        if (hs) begin
          sel_nxt   = BYTE_DATA;
          state_nxt = WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        if (rsp_valid) begin
          if (restart) begin
            take = 1'b1;
          end else if (rsp_nack) begin
            bo_cnt_nxt = '0;
            state_nxt  = (retry < RETRY_LIM) ? BACKOFF : FAIL;
          end else begin
            case (sel)
              BYTE_DEV: state_nxt = SEND_REG;
              BYTE_REG: state_nxt = SEND_DATA;
              default:  state_nxt = NEXT;
            endcase
          end
        end
      end

      NEXT: begin
        idx_nxt   = idx + 4'd1;
        retry_nxt = '0;
        state_nxt = (idx == LAST_IDX) ? DONE : SEND_DEV;
      end

      BACKOFF: begin
        if (restart) begin
          take = 1'b1;
        end else if (bo_last) begin
          retry_nxt = retry + 1'b1;
          state_nxt = SEND_DEV;
        end else begin
          bo_cnt_nxt = bo_cnt + 16'd1;
        end
      end

      DONE: begin
        if (restart) begin
          take = 1'b1;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      FAIL: begin
        if (restart) begin
          take = 1'b1;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Fresh pass from entry 0, whether from IDLE or a hot-plug restart.
    if (take) begin
      state_nxt  = SEND_DEV;
      idx_nxt    = '0;
      retry_nxt  = '0;
      bo_cnt_nxt = '0;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;
      pend_nxt   = 1'b0;
    end
  end

endmodule

// File: doc/hdmi_cfg_sequencer.md
HDMI_CFG_SEQUENCER -- requirements
Module: hdmi_cfg_sequencer

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 8'h72, giving the HDMI transmitter I2C write address (R/W bit = 0).
REQ-002 The block SHALL have parameter RETRY_MAX, default 3, giving the maximum number of retries per table entry after a NACK.
REQ-003 The block SHALL have parameter BACKOFF_CYC, default 16'd1000, giving the idle clocks between a NACK and its retry.
REQ-004 clk  in  1  single clock; the only clock in the block.
REQ-005 rst  in  1  reset, synchronous to clk, active-high.
REQ-006 start  in  1  one-cycle pulse; begins a configuration pass.
REQ-007 hpd  in  1  hot-plug detect, already synchronous to clk.
REQ-008 req_valid  out  1  byte request to the I2C byte master.
REQ-009 req_ready  in  1  master accepts the request when req_valid && req_ready.
REQ-010 req_byte  out  8  byte to transmit.
REQ-011 req_start  out  1  generate START before this byte.
REQ-012 req_stop  out  1  generate STOP after this byte.
REQ-013 rsp_valid  in  1  one-cycle pulse; the byte has completed.
REQ-014 rsp_nack  in  1  qualified by rsp_valid; slave NACKed; the master has already issued STOP.
REQ-015 busy  out  1  a pass is in progress.
REQ-016 done  out  1  sticky; the last pass completed without failure.
REQ-017 error  out  1  sticky; the last pass aborted after exhausting its retries.
REQ-018 entry_idx  out  4  index of the current table entry.

Function
REQ-019 Each table entry SHALL be written as one 3-byte transaction: {DEV_ADDR, req_start=1}, {reg}, {data, req_stop=1}.
REQ-020 The FSM states SHALL be IDLE, SEND_DEV, SEND_REG, SEND_DATA, WAIT_RSP, NEXT, BACKOFF, DONE and FAIL.
REQ-021 The FSM SHALL go IDLE->SEND_DEV on start or on a rising edge of hpd, clearing done, error, entry_idx and the retry count.
REQ-022 In each SEND_* state req_valid SHALL be 1, and req_byte/req_start/req_stop SHALL stay stable until the handshake; the FSM then goes to WAIT_RSP.
REQ-023 At most one byte SHALL be outstanding, so req_valid=0 in WAIT_RSP.
REQ-024 On rsp_valid && !rsp_nack, the FSM SHALL advance to the next SEND_* state; after the data byte it SHALL go to NEXT.
REQ-025 In NEXT, the FSM SHALL increment entry_idx and reset the retry count, going to DONE after entry NUM_ENTRIES-1 and to SEND_DEV otherwise.
REQ-026 On rsp_valid && rsp_nack, on any byte, the FSM SHALL go to BACKOFF if retry count < RETRY_MAX, and to FAIL otherwise.
REQ-027 BACKOFF SHALL count exactly BACKOFF_CYC clocks, increment the retry count, then restart the same entry at SEND_DEV.
REQ-028 DONE SHALL set done=1 and go to IDLE next cycle; FAIL SHALL set error=1 and go to IDLE next cycle.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 A start pulse while busy SHALL be ignored.
REQ-031 An hpd rising edge while busy SHALL be latched as a pending restart, taken at the next WAIT_RSP completion or in BACKOFF, and never while a handshake is open.
REQ-032 A pending restart SHALL be taken in preference to DONE or FAIL on the same cycle.
REQ-033 rsp_valid received outside WAIT_RSP SHALL be ignored.
REQ-034 Counter widths SHALL be sized from the parameters with no wrap: retry count $clog2(RETRY_MAX+1) bits, backoff 16 bits.

Reset
REQ-035 On rst, the FSM SHALL go to IDLE and all outputs SHALL be 0: req_valid, req_byte, req_start, req_stop, busy, done, error, entry_idx.
REQ-036 Reset SHALL clear the pending restart and the hpd edge register, and SHALL take effect at the next clk edge even mid-transaction.

Structure
REQ-037 Package hdmi_cfg_pkg SHALL hold: the state enum; NUM_ENTRIES=10; the 16-bit {reg,data} table constant 41/10, 98/03, 9A/E0, 9C/30, 9D/61, A2/A4, A3/A4, E0/D0, F9/00, 15/00.
REQ-038 Sub-module hdmi_cfg_rom SHALL be combinational, indexed by entry_idx, returning reg and data.
REQ-039 The I2C byte master SHALL be external to this block.

Verification
REQ-040 Bench: start with an always-ACK master model -> 30 bytes in table order, first byte 8'h72 with req_start=1, third byte 8'h10 with req_stop=1; then done=1, busy=0.
REQ-041 Bench: NACK on entry 3's register byte once -> exactly 1000 idle clocks, entry 3 resent from 8'h72; pass completes with done=1.
REQ-042 Bench: NACK on every device byte -> 4 attempts (1+RETRY_MAX), then error=1, done=0, entry_idx=0.
REQ-043 Bench: hpd rise during entry 5 -> the current byte completes, then the restart goes to entry 0 and a full pass completes.
REQ-044 Bench: hold req_ready=0 for 20 cycles -> req_valid and req_byte stay stable; a start pulse meanwhile has no effect.
REQ-045 Bench: rst asserted in WAIT_RSP -> all outputs are 0 the next cycle, and a late rsp_valid is ignored.
